// File: rtl/dds_sweep_if.sv
// Control/status bundle between the sweep controller and its host.
interface dds_sweep_if #(
   parameter int unsigned PINC_W  = 17,
   parameter int unsigned DWELL_W = 16
);
   logic [2:0]         key;
   logic               start;
   logic               stop;
   logic               repeat_en;
   logic [PINC_W-1:0]  f_start;
   logic [PINC_W-1:0]  f_stop;
   logic [PINC_W-1:0]  f_step;
   logic [DWELL_W-1:0] dwell;
   logic [PINC_W-1:0]  pinc;
   logic               pinc_vld;
   logic               sweep_sync;
   logic               busy;
   logic               done;
   logic               cfg_err;

   modport master (
      output key, start, stop, repeat_en, f_start, f_stop, f_step, dwell,
      input  pinc, pinc_vld, sweep_sync, busy, done, cfg_err
   );

   modport slave (
      input  key, start, stop, repeat_en, f_start, f_stop, f_step, dwell,
      output pinc, pinc_vld, sweep_sync, busy, done, cfg_err
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Phase-increment scheduler for the DDS: fixed key-selected increment in IDLE,
// programmable linear sweep (single-shot or repeating) on command.
// Optional macro DEBOUNCE_EN: require DEB_CYC stable cycles of the key before use.
module dds_sweep_ctrl #(
   parameter int unsigned PINC_W   = 17,
   parameter int unsigned DWELL_W  = 16,
   parameter int unsigned FIX_BASE = 262
`ifdef DEBOUNCE_EN
   , parameter int unsigned DEB_CYC = 1024
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   dds_sweep_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         key_s1, key_s2, key_use;
   logic               ok_s1, ok_s2, key_ok;
   logic [PINC_W-1:0]  sh_start_q, sh_start_d, sh_stop_q, sh_stop_d, sh_step_q, sh_step_d;
   logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d, cnt_q, cnt_d, reload;
   logic               sh_rep_q, sh_rep_d;
   logic [PINC_W-1:0]  pinc_q, pinc_d, fixed_pinc;
   logic [PINC_W:0]    nxt;
   logic               vld_q, vld_d, sync_q, sync_d, busy_q, busy_d;
   logic               done_q, done_d, err_q, err_d;

   // Key synchronizer; ok_s* marks when the chain holds real samples so the
   // first fixed update after reset already uses the true key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= '0;
         key_s2 <= '0;
         ok_s1  <= 1'b0;
         ok_s2  <= 1'b0;
      end else begin
         key_s1 <= bus.key;
         key_s2 <= key_s1;
         ok_s1  <= 1'b1;
         ok_s2  <= ok_s1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   logic [2:0]       key_cand, key_deb;
   logic [DEB_W-1:0] deb_cnt;
   logic             deb_ok;

   // Stability window: any change of the synchronized key restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_cand <= '0;
         key_deb  <= '0;
         deb_cnt  <= '0;
         deb_ok   <= 1'b0;
      end else if (key_s2 != key_cand) begin
         key_cand <= key_s2;
         deb_cnt  <= '0;
      end else if (deb_cnt != DEB_W'(DEB_CYC - 1)) begin
         deb_cnt  <= deb_cnt + DEB_W'(1);
      end else begin
         key_deb  <= key_cand;
         deb_ok   <= 1'b1;
      end
   end

   assign key_use = key_deb;
   assign key_ok  = ok_s2 & deb_ok;
`else
   assign key_use = key_s2;
   assign key_ok  = ok_s2;
`endif

   assign fixed_pinc = PINC_W'((32'(key_use) + 32'd1) * FIX_BASE);
   assign nxt        = {1'b0, pinc_q} + {1'b0, sh_step_q};
   assign reload     = (sh_dwell_q == '0) ? '0 : sh_dwell_q - DWELL_W'(1);

   // State, shadow configuration and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sh_start_q <= '0;
         sh_stop_q  <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
         sh_rep_q   <= 1'b0;
         cnt_q      <= '0;
         pinc_q     <= '0;
         vld_q      <= 1'b0;
         sync_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_start_q <= sh_start_d;
         sh_stop_q  <= sh_stop_d;
         sh_step_q  <= sh_step_d;
         sh_dwell_q <= sh_dwell_d;
         sh_rep_q   <= sh_rep_d;
         cnt_q      <= cnt_d;
         pinc_q     <= pinc_d;
         vld_q      <= vld_d;
         sync_q     <= sync_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Next-state and next-output logic; stop always wins over start.
   always_comb begin
      state_d    = state_q;
      sh_start_d = sh_start_q;
      sh_stop_d  = sh_stop_q;
      sh_step_d  = sh_step_q;
      sh_dwell_d = sh_dwell_q;
      sh_rep_d   = sh_rep_q;
      cnt_d      = cnt_q;
      pinc_d     = pinc_q;
      vld_d      = 1'b0;
      sync_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_ok && (fixed_pinc != pinc_q)) begin
               pinc_d = fixed_pinc;
               vld_d  = 1'b1;
            end
            if (bus.start && !bus.stop) begin
               if ((bus.f_step == '0) || (bus.f_start > bus.f_stop)) begin
                  err_d = 1'b1;
               end else begin
                  sh_start_d = bus.f_start;
                  sh_stop_d  = bus.f_stop;
                  sh_step_d  = bus.f_step;
                  sh_dwell_d = bus.dwell;
                  sh_rep_d   = bus.repeat_en;
                  state_d    = LOAD;
               end
            end
         end
         LOAD: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else begin
               pinc_d  = sh_start_q;
               vld_d   = 1'b1;
               sync_d  = 1'b1;
               cnt_d   = reload;
               state_d = DWELL;
            end
         end
         DWELL: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (nxt <= {1'b0, sh_stop_q}) begin
               pinc_d = nxt[PINC_W-1:0];
               vld_d  = 1'b1;
               cnt_d  = reload;
            end else if (sh_rep_q) begin
               // Re-issue f_start on this edge so the last step is not stretched.
               pinc_d = sh_start_q;
               vld_d  = 1'b1;
               sync_d = 1'b1;
               cnt_d  = reload;
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == LOAD) || (state_d == DWELL);
   end

   assign bus.pinc       = pinc_q;
   assign bus.pinc_vld   = vld_q;
   assign bus.sweep_sync = sync_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cfg_err    = err_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized bench for dds_sweep_ctrl against a sequence-level reference model.
module tb_dds_sweep_ctrl;
   localparam int unsigned PINC_W   = 17;
   localparam int unsigned DWELL_W  = 16;
   localparam int unsigned FIX_BASE = 262;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cur_key;
   int   last_pinc;

   always #5 clk = ~clk;

   dds_sweep_if #(.PINC_W(PINC_W), .DWELL_W(DWELL_W)) bus ();

   dds_sweep_ctrl #(.PINC_W(PINC_W), .DWELL_W(DWELL_W), .FIX_BASE(FIX_BASE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int fixed(input int k);
      return (k + 1) * int'(FIX_BASE);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input int p, input bit v, input bit s,
                             input bit b, input bit d, input bit e);
      check({tag, ".pinc"},       32'(bus.pinc),       32'(p));
      check({tag, ".pinc_vld"},   32'(bus.pinc_vld),   32'(v));
      check({tag, ".sweep_sync"}, 32'(bus.sweep_sync), 32'(s));
      check({tag, ".busy"},       32'(bus.busy),       32'(b));
      check({tag, ".done"},       32'(bus.done),       32'(d));
      check({tag, ".cfg_err"},    32'(bus.cfg_err),    32'(e));
   endtask

   task automatic set_cfg(input int fs, input int fe, input int st, input int dw, input bit rep);
      bus.f_start   = PINC_W'(fs);
      bus.f_stop    = PINC_W'(fe);
      bus.f_step    = PINC_W'(st);
      bus.dwell     = DWELL_W'(dw);
      bus.repeat_en = rep;
   endtask

   // Change the key in IDLE: two synchronizer cycles, then the fixed value.
   task automatic key_idle(input int k);
      int fx;
      bus.key = 3'(k);
      cur_key = k;
      tick(); expect_out("key.s1", last_pinc, 0, 0, 0, 0, 0);
      tick(); expect_out("key.s2", last_pinc, 0, 0, 0, 0, 0);
      tick();
      fx = fixed(k);
      expect_out("key.upd", fx, fx != last_pinc, 0, 0, 0, 0);
      last_pinc = fx;
   endtask

   task automatic bad_cfg(input string tag, input int fs, input int fe, input int st, input int dw);
      set_cfg(fs, fe, st, dw, 1'($urandom_range(0, 1)));
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      expect_out({tag, ".err"}, last_pinc, 0, 0, 0, 0, 1);
      tick();
      expect_out({tag, ".after"}, last_pinc, 0, 0, 0, 0, 0);
   endtask

   // Model: the sweep is the list f_start + k*f_step <= f_stop, each value held
   // max(dwell,1) cycles; repeat cycles the list, single-shot adds one done cycle.
   task automatic run_sweep(input string tag, input int fs, input int fe, input int st,
                            input int dw, input bit rep, input int stop_after, input bit chg_key);
      int  vals[$];
      int  d, total, ncyc, hold, p, k, j, fx;
      bit  stopping;
      for (int v = fs; v <= fe; v += st) vals.push_back(v);
      d        = (dw == 0) ? 1 : dw;
      total    = vals.size() * d;
      stopping = (stop_after > 0);
      ncyc     = stopping ? stop_after : total + 1;
      set_cfg(fs, fe, st, dw, rep);
      bus.start = 1'b1;
      tick();
      expect_out({tag, ".load"}, last_pinc, 0, 0, 1, 0, 0);
      hold = last_pinc;
      for (int i = 0; i < ncyc; i++) begin
         bus.start = 1'($urandom_range(0, 1));
         set_cfg(int'($urandom_range(0, 131071)), int'($urandom_range(0, 131071)),
                 int'($urandom_range(0, 131071)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
         tick();
         if (!rep && i == total) begin
            expect_out({tag, ".done"}, hold, 0, 0, 0, 1, 0);
         end else begin
            p    = i % total;
            k    = p / d;
            j    = p % d;
            hold = vals[k];
            expect_out({tag, ".run"}, hold, j == 0, (j == 0) && (k == 0), 1, 0, 0);
         end
         if (i == 0 && chg_key && (!stopping || stop_after >= 2)) begin
            cur_key = int'($urandom_range(0, 7));
            bus.key = 3'(cur_key);
         end
      end
      bus.start = 1'b0;
      if (stopping) begin
         bus.stop = 1'b1;
         tick();
         bus.stop = 1'b0;
         expect_out({tag, ".stop"}, hold, 0, 0, 0, 0, 0);
      end else begin
         tick();
         expect_out({tag, ".idle"}, hold, 0, 0, 0, 0, 0);
      end
      tick();
      fx = fixed(cur_key);
      expect_out({tag, ".fixed"}, fx, fx != hold, 0, 0, 0, 0);
      last_pinc = fx;
   endtask

   initial begin
      int vc, fs, fe, st, dw, d, total, sa;
      bit rep;
      cur_key   = 3;
      bus.key   = 3'd3;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      set_cfg(0, 0, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      expect_out("rst", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      vc = 0;
      repeat (3) begin
         tick();
         vc += int'(bus.pinc_vld);
      end
      check("rst.pinc", 32'(bus.pinc), 32'd1048);
      check("rst.vld_count", 32'(vc), 32'd1);
      check("rst.busy", 32'(bus.busy), 32'd0);
      last_pinc = 1048;
      tick();
      expect_out("rst.hold", 1048, 0, 0, 0, 0, 0);

      run_sweep("single", 100, 400, 100, 4, 1'b0, 0, 1'b0);
      run_sweep("repeat", 100, 400, 100, 0, 1'b1, 10, 1'b0);
      bad_cfg("step0", 100, 400, 0, 4);
      bad_cfg("inverted", 500, 400, 100, 4);
      run_sweep("stop300", 100, 400, 100, 4, 1'b0, 9, 1'b0);

      set_cfg(100, 400, 100, 4, 1'b0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      expect_out("startstop", last_pinc, 0, 0, 0, 0, 0);
      tick();
      expect_out("startstop.after", last_pinc, 0, 0, 0, 0, 0);

      run_sweep("top", 'h1FF00, 'h1FFFF, 'h80, 2, 1'b0, 0, 1'b0);
      run_sweep("equal", 777, 777, 5, 3, 1'b0, 0, 1'b0);
      run_sweep("equal_rep", 777, 777, 5, 1, 1'b1, 4, 1'b0);

      set_cfg(1000, 3000, 200, 3, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1 expect_out("midrst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      vc = 0;
      repeat (3) begin
         tick();
         vc += int'(bus.pinc_vld);
      end
      check("midrst.pinc", 32'(bus.pinc), 32'(fixed(cur_key)));
      check("midrst.vld_count", 32'(vc), 32'd1);
      last_pinc = fixed(cur_key);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) key_idle(int'($urandom_range(0, 7)));
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               fs = int'($urandom_range(0, 100000));
               bad_cfg("rnd.step0", fs, fs + int'($urandom_range(0, 1500)), 0, 2);
            end else begin
               fs = int'($urandom_range(1000, 120000));
               bad_cfg("rnd.inv", fs, fs - int'($urandom_range(1, 999)),
                       int'($urandom_range(1, 600)), 2);
            end
         end else begin
            fs    = int'($urandom_range(0, 120000));
            fe    = fs + int'($urandom_range(0, 1500));
            st    = int'($urandom_range(100, 600));
            dw    = int'($urandom_range(0, 3));
            rep   = 1'($urandom_range(0, 1));
            d     = (dw == 0) ? 1 : dw;
            total = ((fe - fs) / st + 1) * d;
            if (rep) sa = int'($urandom_range(1, 2 * total + 2));
            else if ($urandom_range(0, 2) == 0) sa = int'($urandom_range(1, total));
            else sa = 0;
            run_sweep("rnd", fs, fe, st, dw, rep, sa, 1'b1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
